reg_read_unit: RTL

REG_READ_UNIT -- requirements
Module: reg_read_unit

---
 rtl/reg_read_unit_pkg.sv | 19 +
 rtl/reg_read_unit_if.sv | 53 +++++
 rtl/reg_read_unit_scoreboard.sv | 55 +++++
 rtl/reg_read_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/reg_read_unit_pkg.sv
// Shared definitions for the register-read unit.
// Provides the FSM state encoding, the default index/data widths and the
// default register count derived from the index width.
package reg_read_unit_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int NREGS          = 2 ** DEF_ADDR_WIDTH;

    // IDLE: waiting for an instruction; RD1/RD2: resolving rs1/rs2;
    // OUT: operands presented to execute.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_read_unit_if.sv
// Bundle of every signal of the register-read unit except clock and reset.
//   in_*      : decoded instruction handshake (valid/ready) and indices
//   rf_*      : register-file read port (index out, data in, combinational)
//   wb_*      : writeback observed this cycle
//   out_*     : operand handshake towards execute
// Modport slave is the unit's view, master is the surrounding pipeline's view.
interface reg_read_unit_if
    import reg_read_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rs1;
    logic [ADDR_WIDTH-1:0] in_rs2;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_rd_wen;

    logic [ADDR_WIDTH-1:0] rf_raddr;
    logic [DATA_WIDTH-1:0] rf_rdata;

    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_src1;
    logic [DATA_WIDTH-1:0] out_src2;
    logic [ADDR_WIDTH-1:0] out_rd;
    logic                  out_rd_wen;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
        input  rf_rdata,
        input  wb_valid, wb_addr, wb_data,
        input  out_ready,
        output in_ready, rf_raddr,
        output out_valid, out_src1, out_src2, out_rd, out_rd_wen
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
        output rf_rdata,
        output wb_valid, wb_addr, wb_data,
        output out_ready,
        input  in_ready, rf_raddr,
        input  out_valid, out_src1, out_src2, out_rd, out_rd_wen
    );

endinterface

// File: rtl/reg_read_unit_scoreboard.sv
// reg_scoreboard: one pending-write bit per architectural register.
//   clk, rst            : clock, synchronous active-high reset (clears all bits)
//   set_en, set_addr    : mark a register as awaiting writeback
//   clr_en, clr_addr    : writeback seen, register no longer pending
//   lk1_addr/lk1_busy   : combinational lookup port 1
//   lk2_addr/lk2_busy   : combinational lookup port 2
// A set and a clear of the same index in one cycle leaves the bit set, since
// the new producer is younger than the writeback being retired.
// Bit 0 is hard-wired to 0 because x0 is never written.
module reg_scoreboard
    import reg_read_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NREGS      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] lk1_addr,
    output logic                  lk1_busy,
    input  logic [ADDR_WIDTH-1:0] lk2_addr,
    output logic                  lk2_busy
);

    logic [NREGS-1:0] busy_vec;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                assign busy_vec[gi] = 1'b0;
            end else begin : g_live
                logic bit_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        bit_reg <= 1'b0;
                    end else if (set_en && (set_addr == ADDR_WIDTH'(gi))) begin
                        bit_reg <= 1'b1;
                    end else if (clr_en && (clr_addr == ADDR_WIDTH'(gi))) begin
                        bit_reg <= 1'b0;
                    end
                end

                assign busy_vec[gi] = bit_reg;
            end
        end
    endgenerate

    assign lk1_busy = busy_vec[lk1_addr];
    assign lk2_busy = busy_vec[lk2_addr];

endmodule

// File: rtl/reg_read_unit.sv
// reg_read_unit: fetches the two source operands of one instruction at a time.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, overrides every handshake/writeback
//   bus  : reg_read_unit_if.slave -- instruction input handshake, external
//          register-file read port, writeback snoop, operand output handshake
// Flow: IDLE accepts an instruction, RD1 resolves rs1, RD2 resolves rs2, OUT
// holds the operands until execute accepts. Each source is taken as zero for
// x0, forwarded from a same-cycle writeback, stalled while a prior
// instruction's write is still pending, or else read from the register file.
// The destination is marked pending when execute accepts the instruction.
module reg_read_unit
    import reg_read_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    reg_read_unit_if.slave bus
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] rs1_reg;
    logic [ADDR_WIDTH-1:0] rs2_reg;
    logic [ADDR_WIDTH-1:0] rd_reg;
    logic                  rd_wen_reg;
    logic [ADDR_WIDTH-1:0] raddr_reg;
    logic [DATA_WIDTH-1:0] src1_reg;
    logic [DATA_WIDTH-1:0] src2_reg;
    logic                  in_ready_reg;
    logic                  out_valid_reg;

    logic                  busy1;
    logic                  busy2;
    logic                  cur_busy;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  opnd_ok;
    logic [DATA_WIDTH-1:0] opnd_val;
    logic                  out_fire;
    logic                  sb_set_en;

    assign out_fire  = out_valid_reg && bus.out_ready;
    // x0 is never tracked, so a completing write to it leaves nothing pending.
    assign sb_set_en = out_fire && rd_wen_reg && (rd_reg != '0);

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NREGS      (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set_en),
        .set_addr (rd_reg),
        .clr_en   (bus.wb_valid),
        .clr_addr (bus.wb_addr),
        .lk1_addr (rs1_reg),
        .lk1_busy (busy1),
        .lk2_addr (rs2_reg),
        .lk2_busy (busy2)
    );

    // Source being resolved this cycle; only meaningful in RD1/RD2.
    always_comb begin
        cur_idx  = rs1_reg;
        cur_busy = busy1;
        if (state_reg == RD2) begin
            cur_idx  = rs2_reg;
            cur_busy = busy2;
        end
    end

    // Forwarding beats the pending bit: the writeback that would clear the
    // bit at this edge already carries the value we are waiting for.
    always_comb begin
        opnd_ok  = 1'b1;
        opnd_val = '0;
        if (cur_idx == '0) begin
            opnd_val = '0;
        end else if (bus.wb_valid && (bus.wb_addr == cur_idx)) begin
            opnd_val = bus.wb_data;
        end else if (cur_busy) begin
            opnd_ok = 1'b0;
        end else begin
            opnd_val = bus.rf_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            rd_reg        <= '0;
            rd_wen_reg    <= 1'b0;
            raddr_reg     <= '0;
            src1_reg      <= '0;
            src2_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        rs1_reg      <= bus.in_rs1;
                        rs2_reg      <= bus.in_rs2;
                        rd_reg       <= bus.in_rd;
                        rd_wen_reg   <= bus.in_rd_wen;
                        raddr_reg    <= bus.in_rs1;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RD1;
                    end
                end
                RD1: begin
                    if (opnd_ok) begin
                        src1_reg  <= opnd_val;
                        raddr_reg <= rs2_reg;
                        state_reg <= RD2;
                    end
                end
                RD2: begin
                    if (opnd_ok) begin
                        src2_reg      <= opnd_val;
                        raddr_reg     <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.rf_raddr   = raddr_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_src1   = src1_reg;
    assign bus.out_src2   = src2_reg;
    assign bus.out_rd     = rd_reg;
    assign bus.out_rd_wen = rd_wen_reg;

endmodule
